lane_deserializer: RTL and testbench

LANE_DESERIALIZER -- requirements
Module: lane_deserializer

---
 rtl/lane_deserializer_if.sv | 24 ++
 rtl/lane_deserializer.sv | 177 +++++++++++++++++
 tb/tb_lane_deserializer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lane_deserializer_if.sv
// lane_deserializer_if: sample strobe, serial lanes and decoded-frame outputs of the lane deserializer
interface lane_deserializer_if #(parameter int PAYLOAD_BEATS = 16);
   logic                         sample_en;
   logic                         serial_in_h;
   logic                         serial_in_0;
   logic                         serial_in_1;
   logic                         serial_in_2;
   logic                         serial_in_3;
   logic                         pkt_valid;
   logic [3:0]                   pkt_type;
   logic                         pkt_seq;
   logic [4*PAYLOAD_BEATS-1:0]   pkt_payload;
   logic                         chk_err;
   logic                         timeout_err;
   logic                         busy;
   modport master (
      output sample_en, serial_in_h, serial_in_0, serial_in_1, serial_in_2, serial_in_3,
      input  pkt_valid, pkt_type, pkt_seq, pkt_payload, chk_err, timeout_err, busy
   );
   modport slave (
      input  sample_en, serial_in_h, serial_in_0, serial_in_1, serial_in_2, serial_in_3,
      output pkt_valid, pkt_type, pkt_seq, pkt_payload, chk_err, timeout_err, busy
   );
endinterface

// File: rtl/lane_deserializer.sv
// lane_deserializer: hunts a header-lane sync word, then collects header, 4-lane payload and checksum.
// Optional error counters are enabled with the macro LANE_DESER_ERR_CNT_EN.
module lane_deserializer #(
   parameter int         PAYLOAD_BEATS  = 16,
   parameter int         TIMEOUT_CYCLES = 2000,
   parameter logic [7:0] SYNC_WORD      = 8'hA5
) (
   input  logic                clk,
   input  logic                rst_l,
   lane_deserializer_if.slave  lif
`ifdef LANE_DESER_ERR_CNT_EN
   ,
   output logic [7:0]          chk_err_cnt,
   output logic [7:0]          timeout_cnt
`endif
);
   localparam int CW = $clog2(PAYLOAD_BEATS > 5 ? PAYLOAD_BEATS : 5);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PW = 4 * PAYLOAD_BEATS;

   typedef enum logic [1:0] {HUNT, HDR, DATA, CHK} state_e;

   state_e          state_q, state_d;
   logic [7:0]      sr_q, sr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      hdr_q, hdr_d;
   logic [PW-1:0]   pay_st_q, pay_st_d;
   logic [3:0]      csum_q, csum_d;
   logic [3:0]      chk_q, chk_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            pkt_valid_q, pkt_valid_d;
   logic            chk_err_q, chk_err_d;
   logic            timeout_err_q, timeout_err_d;
   logic [3:0]      type_q, type_d;
   logic            seq_q, seq_d;
   logic [PW-1:0]   payload_q, payload_d;
   logic [3:0]      nib;

   assign nib = {lif.serial_in_3, lif.serial_in_2, lif.serial_in_1, lif.serial_in_0};

   // Next-state: sampling only happens on strobes; a stalled frame is dropped once the timeout expires.
   always_comb begin
      state_d       = state_q;
      sr_d          = sr_q;
      cnt_d         = cnt_q;
      hdr_d         = hdr_q;
      pay_st_d      = pay_st_q;
      csum_d        = csum_q;
      chk_d         = chk_q;
      tmo_d         = (state_q == HUNT || lif.sample_en) ? '0 : tmo_q + 1'b1;
      pkt_valid_d   = 1'b0;
      chk_err_d     = 1'b0;
      timeout_err_d = 1'b0;
      type_d        = type_q;
      seq_d         = seq_q;
      payload_d     = payload_q;
      if (lif.sample_en) begin
         case (state_q)
            HUNT: begin
               sr_d = {sr_q[6:0], lif.serial_in_h};
               if (sr_d == SYNC_WORD) begin
                  state_d = HDR;
                  cnt_d   = '0;
                  csum_d  = '0;
               end
            end
            HDR: begin
               hdr_d = {hdr_q[3:0], lif.serial_in_h};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(4)) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end
            end
            DATA: begin
               pay_st_d[{cnt_q, 2'b00} +: 4] = nib;
               csum_d = csum_q ^ nib;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CW'(PAYLOAD_BEATS - 1)) begin
                  state_d = CHK;
                  cnt_d   = '0;
               end
            end
            default: begin
               chk_d = {chk_q[2:0], lif.serial_in_h};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(3)) begin
                  state_d = HUNT;
                  cnt_d   = '0;
                  sr_d    = '0;
                  if (chk_d == (csum_q ^ hdr_q[4:1] ^ {3'b0, hdr_q[0]})) begin
                     pkt_valid_d = 1'b1;
                     type_d      = hdr_q[4:1];
                     seq_d       = hdr_q[0];
                     payload_d   = pay_st_q;
                  end else begin
                     chk_err_d = 1'b1;
                  end
               end
            end
         endcase
      end else if (state_q != HUNT && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d       = HUNT;
         cnt_d         = '0;
         sr_d          = '0;
         timeout_err_d = 1'b1;
      end
   end

   // State and output registers; reset discards any partial frame immediately.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q       <= HUNT;
         sr_q          <= '0;
         cnt_q         <= '0;
         hdr_q         <= '0;
         pay_st_q      <= '0;
         csum_q        <= '0;
         chk_q         <= '0;
         tmo_q         <= '0;
         pkt_valid_q   <= 1'b0;
         chk_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         type_q        <= '0;
         seq_q         <= 1'b0;
         payload_q     <= '0;
      end else begin
         state_q       <= state_d;
         sr_q          <= sr_d;
         cnt_q         <= cnt_d;
         hdr_q         <= hdr_d;
         pay_st_q      <= pay_st_d;
         csum_q        <= csum_d;
         chk_q         <= chk_d;
         tmo_q         <= tmo_d;
         pkt_valid_q   <= pkt_valid_d;
         chk_err_q     <= chk_err_d;
         timeout_err_q <= timeout_err_d;
         type_q        <= type_d;
         seq_q         <= seq_d;
         payload_q     <= payload_d;
      end
   end

   assign lif.pkt_valid   = pkt_valid_q;
   assign lif.chk_err     = chk_err_q;
   assign lif.timeout_err = timeout_err_q;
   assign lif.pkt_type    = type_q;
   assign lif.pkt_seq     = seq_q;
   assign lif.pkt_payload = payload_q;
   assign lif.busy        = (state_q != HUNT);

`ifdef LANE_DESER_ERR_CNT_EN
   logic [7:0] chk_err_cnt_q, chk_err_cnt_d;
   logic [7:0] timeout_cnt_q, timeout_cnt_d;

   // Saturating error counters advance on the cycle each error pulse is raised.
   always_comb begin
      chk_err_cnt_d = (chk_err_d && chk_err_cnt_q != 8'hFF) ? chk_err_cnt_q + 8'd1 : chk_err_cnt_q;
      timeout_cnt_d = (timeout_err_d && timeout_cnt_q != 8'hFF) ? timeout_cnt_q + 8'd1 : timeout_cnt_q;
   end

   // Error counter registers.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         chk_err_cnt_q <= '0;
         timeout_cnt_q <= '0;
      end else begin
         chk_err_cnt_q <= chk_err_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

   assign chk_err_cnt = chk_err_cnt_q;
   assign timeout_cnt = timeout_cnt_q;
`endif
endmodule

// File: tb/tb_lane_deserializer.sv
// tb_lane_deserializer: directed frames with a scoreboard queue checked by an output monitor.
module tb_lane_deserializer;
   logic clk = 1'b0;
   logic rst_l = 1'b0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      logic [2:0]  kind;
      logic [3:0]  ptype;
      logic        seq;
      logic [63:0] payload;
   } ev_t;

   ev_t         sb[$];
   logic [3:0]  last_type = 4'h0;
   logic        last_seq = 1'b0;
   logic [63:0] last_pay = 64'h0;

   lane_deserializer_if #(.PAYLOAD_BEATS(16)) lif ();
`ifdef LANE_DESER_ERR_CNT_EN
   logic [7:0] chk_err_cnt, timeout_cnt;
`endif

   lane_deserializer dut (
      .clk   (clk),
      .rst_l (rst_l),
      .lif   (lif.slave)
`ifdef LANE_DESER_ERR_CNT_EN
      ,
      .chk_err_cnt (chk_err_cnt),
      .timeout_cnt (timeout_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // kind is one-hot {timeout_err, chk_err, pkt_valid}
   task automatic expect_ev(input logic [2:0] kind);
      ev_t e;
      e.kind = kind;
      e.ptype = last_type;
      e.seq = last_seq;
      e.payload = last_pay;
      sb.push_back(e);
   endtask

   // Monitor: every output pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (rst_l && (lif.pkt_valid || lif.chk_err || lif.timeout_err)) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {61'b0, lif.timeout_err, lif.chk_err, lif.pkt_valid}, 64'h0);
         end else begin
            ev_t e;
            e = sb.pop_front();
            check("pulse_kind", {61'b0, lif.timeout_err, lif.chk_err, lif.pkt_valid}, {61'b0, e.kind});
            check("pkt_type", {60'b0, lif.pkt_type}, {60'b0, e.ptype});
            check("pkt_seq", {63'b0, lif.pkt_seq}, {63'b0, e.seq});
            check("pkt_payload", lif.pkt_payload, e.payload);
         end
      end
   end

   task automatic strobe(input logic h, input logic [3:0] d);
      @(posedge clk);
      #1;
      lif.sample_en = 1'b1;
      lif.serial_in_h = h;
      {lif.serial_in_3, lif.serial_in_2, lif.serial_in_1, lif.serial_in_0} = d;
      @(posedge clk);
      #1;
      lif.sample_en = 1'b0;
   endtask

   task automatic send_head(input logic [3:0] t, input logic s);
      logic [7:0] sw;
      logic [4:0] hb;
      sw = 8'hA5;
      hb = {t, s};
      for (int i = 7; i >= 0; i--) strobe(sw[i], 4'h0);
      for (int i = 4; i >= 0; i--) strobe(hb[i], 4'h0);
   endtask

   task automatic send_beats(input logic [63:0] p, input logic [15:0] hd, input int first, input int n);
      for (int k = first; k < first + n; k++) strobe(hd[15-k], p[4*k +: 4]);
   endtask

   task automatic send_chk(input logic [3:0] c);
      for (int i = 3; i >= 0; i--) strobe(c[i], 4'h0);
   endtask

   task automatic good_frame(input logic [3:0] t, input logic s, input logic [63:0] p, input logic [3:0] c, input logic [15:0] hd);
      last_type = t;
      last_seq = s;
      last_pay = p;
      expect_ev(3'b001);
      send_head(t, s);
      send_beats(p, hd, 0, 16);
      send_chk(c);
   endtask

   task automatic drain(input string name);
      repeat (3) @(posedge clk);
      #1;
      check(name, 64'(sb.size()), 64'h0);
   endtask

   initial begin
      lif.sample_en = 1'b0;
      lif.serial_in_h = 1'b0;
      {lif.serial_in_3, lif.serial_in_2, lif.serial_in_1, lif.serial_in_0} = 4'h0;
      #2;
      check("rst_busy", {63'b0, lif.busy}, 64'h0);
      check("rst_pulses", {61'b0, lif.timeout_err, lif.chk_err, lif.pkt_valid}, 64'h0);
      check("rst_type", {60'b0, lif.pkt_type}, 64'h0);
      check("rst_seq", {63'b0, lif.pkt_seq}, 64'h0);
      check("rst_payload", lif.pkt_payload, 64'h0);
      repeat (2) @(posedge clk);
      #3;
      rst_l = 1'b1;

      // Good frame: type 3, seq 1, all nibbles 1, checksum 3^1 = 2
      good_frame(4'h3, 1'b1, 64'h1111_1111_1111_1111, 4'h2, 16'h0);
      drain("good_drain");
      check("idle_busy", {63'b0, lif.busy}, 64'h0);

      // Same frame with wrong checksum 0: chk_err, outputs unchanged
      expect_ev(3'b010);
      send_head(4'h3, 1'b1);
      send_beats(64'h1111_1111_1111_1111, 16'h0, 0, 16);
      send_chk(4'h0);
      drain("chkerr_drain");
`ifdef LANE_DESER_ERR_CNT_EN
      check("chk_err_cnt", {56'b0, chk_err_cnt}, 64'h1);
`endif

      // Sync pattern on header lane during DATA; xor of nibbles 0..F is 0, checksum 0^5^0 = 5
      good_frame(4'h5, 1'b0, 64'h0123_4567_89AB_CDEF, 4'h5, 16'hA5A5);
      drain("embed_drain");

      // Stall after beat 5 for more than the timeout
      send_head(4'h6, 1'b0);
      send_beats(64'h9999_9999_9999_9999, 16'h0, 0, 6);
      check("stall_busy", {63'b0, lif.busy}, 64'h1);
      expect_ev(3'b100);
      repeat (2010) @(posedge clk);
      #1;
      check("tmo_busy", {63'b0, lif.busy}, 64'h0);
      drain("tmo_drain");
`ifdef LANE_DESER_ERR_CNT_EN
      check("timeout_cnt", {56'b0, timeout_cnt}, 64'h1);
`endif
      // Recovery frame: sixteen 2s xor to 0, checksum A^1 = B
      good_frame(4'hA, 1'b1, 64'h2222_2222_2222_2222, 4'hB, 16'h0);
      drain("recover_drain");

      // Asynchronous reset in the middle of DATA
      send_head(4'h4, 1'b1);
      send_beats(64'h7777_7777_7777_7777, 16'h0, 0, 3);
      @(posedge clk);
      #3;
      rst_l = 1'b0;
      #1;
      check("arst_busy", {63'b0, lif.busy}, 64'h0);
      check("arst_type", {60'b0, lif.pkt_type}, 64'h0);
      check("arst_seq", {63'b0, lif.pkt_seq}, 64'h0);
      check("arst_payload", lif.pkt_payload, 64'h0);
      last_type = 4'h0;
      last_seq = 1'b0;
      last_pay = 64'h0;
      repeat (2) @(posedge clk);
      #3;
      rst_l = 1'b1;
      // Eight Fs xor to 0, checksum 0^7 = 7
      good_frame(4'h7, 1'b0, 64'hFFFF_0000_FFFF_0000, 4'h7, 16'h0);
      drain("post_rst_drain");

      // Back-to-back: 5^1^0 = 4, then 3^2^1 = 0
      good_frame(4'h1, 1'b0, 64'h0000_0000_0000_0005, 4'h4, 16'h0);
      good_frame(4'h2, 1'b1, 64'h0000_0000_0000_0003, 4'h0, 16'h0);
      drain("b2b_drain");
      check("final_seq", {63'b0, lif.pkt_seq}, 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
